// File: rtl/dbg_uart_rx.sv
// dbg_uart_rx: 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output register
// CLK, RESET: sole clock and synchronous active-high reset
// RXD: asynchronous serial input, idles high
// DATA, DATA_VALID, DATA_READY: received word held until accepted
// FRAME_ERR, OVERRUN: one-cycle error pulses; BUSY: receiver not idle
module dbg_uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DATA_VALID,
  input  logic                 DATA_READY,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST = IW'(DATA_BITS - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP, ST_BREAK} state_t;
  state_t state, state_n;
  logic rx_meta, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic deliver, ferr;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rxs <= 1'b1;
      state <= ST_IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      DATA <= '0;
      DATA_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN <= 1'b0;
    end else begin
      rx_meta <= RXD;
      rxs <= rx_meta;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      FRAME_ERR <= ferr;
      OVERRUN <= deliver && DATA_VALID && !DATA_READY;
      if (deliver && (!DATA_VALID || DATA_READY)) begin
        DATA <= shift;
        DATA_VALID <= 1'b1;
      end else if (DATA_READY) begin
        DATA_VALID <= 1'b0;
      end
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    shift_n = shift;
    deliver = 1'b0;
    ferr = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        state_n = rxs ? ST_IDLE : ST_START;
      end
      ST_START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rxs ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (cnt == FULL) begin
        cnt_n = '0;
        shift_n[idx] = rxs;
        idx_n = (idx == LAST) ? idx : idx + 1'b1;
        state_n = (idx == LAST) ? ST_STOP : ST_DATA;
      end
      ST_STOP: if (cnt == FULL) begin
        cnt_n = '0;
        deliver = rxs;
        ferr = !rxs;
        state_n = rxs ? ST_IDLE : ST_BREAK;
      end
      ST_BREAK: begin
        cnt_n = '0;
        state_n = rxs ? ST_IDLE : ST_BREAK;
      end
      default: state_n = ST_IDLE;
    endcase
  end
  assign BUSY = state != ST_IDLE;
endmodule

// File: tb/tb_dbg_uart_rx.sv
// tb_dbg_uart_rx: directed and randomized frame checks of dbg_uart_rx against a frame-level model
module tb_dbg_uart_rx;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst, rxd, ready;
  logic [7:0] data;
  logic valid, ferr, ovr, busy;
  int checks = 0, fails = 0;
  int n_ferr = 0, n_ovr = 0, n_both = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  dbg_uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .CLK(clk), .RESET(rst), .RXD(rxd), .DATA(data), .DATA_VALID(valid),
    .DATA_READY(ready), .FRAME_ERR(ferr), .OVERRUN(ovr), .BUSY(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    #2;
    if (valid && ready) got.push_back(data);
    if (ferr) n_ferr++;
    if (ovr) n_ovr++;
    if (ferr && ovr) n_both++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(CPB);
    end
    rxd = stop;
    idle(CPB);
  endtask
  initial begin
    int fe0, ov0, exp_fe;
    logic [7:0] b;
    logic st;
    rst = 1'b1;
    rxd = 1'b1;
    ready = 1'b0;
    idle(3);
    chk("reset_data", data, 0);
    chk("reset_valid", valid, 0);
    chk("reset_flags", {ferr, ovr, busy}, 0);
    rst = 1'b0;
    idle(4);
    ready = 1'b1;
    got.delete();
    fe0 = n_ferr;
    ov0 = n_ovr;
    send(8'hA5, 1'b1);
    idle(6);
    chk("t1_count", got.size(), 1);
    chk("t1_data", got.size() > 0 ? got[0] : 8'hxx, 8'hA5);
    chk("t1_errs", (n_ferr - fe0) + (n_ovr - ov0), 0);
    chk("t1_busy", busy, 0);
    chk("t1_valid_low", valid, 0);
    got.delete();
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(12);
    chk("t2_count", got.size(), 0);
    chk("t2_ferr", n_ferr - fe0, 0);
    chk("t2_busy", busy, 0);
    send(8'h3C, 1'b0);
    idle(40);
    chk("t3_ferr", n_ferr - fe0, 1);
    chk("t3_valid", valid, 0);
    chk("t3_busy_break", busy, 1);
    rxd = 1'b1;
    idle(8);
    chk("t3_idle", busy, 0);
    send(8'h01, 1'b1);
    idle(6);
    chk("t3_next_count", got.size(), 1);
    chk("t3_next_data", got.size() > 0 ? got[0] : 8'hxx, 8'h01);
    chk("t3_ferr_once", n_ferr - fe0, 1);
    got.delete();
    ready = 1'b0;
    ov0 = n_ovr;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    idle(6);
    chk("t4_data", data, 8'h11);
    chk("t4_valid", valid, 1);
    chk("t4_ovr", n_ovr - ov0, 1);
    chk("t4_none_taken", got.size(), 0);
    ready = 1'b1;
    idle(3);
    chk("t4_valid_drop", valid, 0);
    chk("t4_taken", got.size(), 1);
    chk("t4_taken_data", got.size() > 0 ? got[0] : 8'hxx, 8'h11);
    got.delete();
    ready = 1'b0;
    ov0 = n_ovr;
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    ready = 1'b1;
    idle(1);
    ready = 1'b0;
    idle(2);
    chk("t5_data", data, 8'h22);
    chk("t5_valid", valid, 1);
    chk("t5_ovr", n_ovr - ov0, 0);
    chk("t5_taken", got.size(), 1);
    chk("t5_taken_data", got.size() > 0 ? got[0] : 8'hxx, 8'h11);
    ready = 1'b1;
    idle(3);
    got.delete();
    ready = 1'b0;
    send(8'h55, 1'b1);
    idle(4);
    chk("t6_held", {valid, data}, {1'b1, 8'h55});
    rxd = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      rxd = 1'b1;
      idle(CPB);
    end
    chk("t6_busy_mid", busy, 1);
    rst = 1'b1;
    idle(1);
    chk("t6_reset_outs", {data, valid, ferr, ovr, busy}, 0);
    rst = 1'b0;
    rxd = 1'b1;
    idle(8);
    ready = 1'b1;
    got.delete();
    send(8'h80, 1'b1);
    idle(6);
    chk("t6_count", got.size(), 1);
    chk("t6_data", got.size() > 0 ? got[0] : 8'hxx, 8'h80);
    got.delete();
    exp_q.delete();
    fe0 = n_ferr;
    exp_fe = 0;
    for (int k = 0; k < 24; k++) begin
      b = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      if (st) exp_q.push_back(b);
      else exp_fe++;
      send(b, st);
      if (!st) begin
        rxd = 1'b1;
        idle(CPB);
      end
    end
    idle(8);
    chk("rand_count", got.size(), exp_q.size());
    chk("rand_ferr", n_ferr - fe0, exp_fe);
    for (int k = 0; k < exp_q.size(); k++)
      chk("rand_byte", k < got.size() ? got[k] : 8'hxx, exp_q[k]);
    chk("flags_exclusive", n_both, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
